// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the instruction fetch stage.
//   INSTR_NOP        - word shown to decode when no instruction is buffered
//   DEFAULT_RESET_PC - default fetch PC after reset
//   fetch_entry_t    - one prefetch FIFO entry {instr, pc}
//   align_word()     - clears the byte-offset bits of an address
package fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pc} words.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_data       write one entry
//   pop                   drop the head entry
//   flush                 discard everything (wins over push/pop)
//   rd_data               head entry
//   count, empty, full    occupancy
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read while count_q > 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the fetch PC, issues word requests to instruction memory, buffers
// in-order responses with their PCs, and handles redirects by flushing the
// buffer and dropping stale in-flight responses.
// Optional build macro: FETCH_BYPASS_EN - a response arriving while the FIFO
// is empty and decode is ready goes straight to decode in the same cycle.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   imem_req_valid/addr/ready         request channel to instruction memory
//   imem_rsp_valid/data               in-order response channel
//   redirect_valid/pc                 change of control flow
//   instr_valid/instr/instr_pc/ready  handshake to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CREDITS = DEPTH[CNT_W:0];

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pc_rsp_q, pc_rsp_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic             fifo_push, fifo_pop, fifo_flush;
  fetch_entry_t     fifo_head, fifo_wdata;

  logic             req_fire, rsp_keep, bypass;
  logic [31:0]      redirect_target;
  logic [CNT_W:0]   credits_used;

  // Request / response control
  always_comb begin
    redirect_target = align_word(redirect_pc);
    // In-flight plus buffered words never exceed DEPTH, so the FIFO cannot overflow.
    credits_used    = {1'b0, inflight_q} + {1'b0, fifo_count};
    imem_req_valid  = !rst && !redirect_valid && (credits_used < CREDITS);
    imem_req_addr   = align_word(fetch_pc_q);
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_keep        = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass          = rsp_keep && fifo_empty && instr_ready;
`else
    bypass          = 1'b0;
`endif
    fifo_flush      = redirect_valid;
    // A word visible during a redirect is flushed, not consumed.
    fifo_pop        = !fifo_empty && instr_ready && !redirect_valid;
    fifo_push       = rsp_keep && !bypass && (!fifo_full || fifo_pop);
    fifo_wdata      = '{instr: imem_rsp_data, pc: pc_rsp_q};
  end

  // PC / credit / drop bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_rsp_d   = pc_rsp_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      pc_rsp_d   = redirect_target;
      // Only responses still outstanding after this cycle need dropping.
      drop_cnt_d = inflight_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (rsp_keep) begin
        pc_rsp_d = pc_rsp_q + PC_STEP;
      end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pc_rsp_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_rsp_q   <= pc_rsp_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Decode-side outputs; when empty, instr_pc shows the next expected PC.
  always_comb begin
    instr_valid = !fifo_empty || bypass;
    if (bypass) begin
      instr    = imem_rsp_data;
      instr_pc = pc_rsp_q;
    end else if (!fifo_empty) begin
      instr    = fifo_head.instr;
      instr_pc = fifo_head.pc;
    end else begin
      instr    = INSTR_NOP;
      instr_pc = pc_rsp_q;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(fifo_wdata),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .rd_data  (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];
  logic [31:0] req_log[$];

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  // End of cycle: record accepted requests and consumed words, then move to
  // the next cycle and drive whatever response the memory model has due.
  task automatic step();
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      req_log.push_back(imem_req_addr);
    end
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      log_pc.push_back(instr_pc);
      log_instr.push_back(instr);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
      pend_q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic clear_logs();
    log_pc.delete();
    log_instr.delete();
    req_log.delete();
  endtask

  task automatic apply_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend_q.delete();
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== NOP) begin failures++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    apply_reset();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL c0_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    step();
`ifdef FETCH_BYPASS_EN
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL c1_bypass: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
`else
    checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin failures++; $display("FAIL c1_instr: got v=%b i=%h want v=0 i=%h", instr_valid, instr, NOP); end
`endif
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL c1_req: got v=%b a=%h want v=1 a=4", imem_req_valid, imem_req_addr); end
    step();
`ifdef FETCH_BYPASS_EN
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== ~32'h4) begin failures++; $display("FAIL c2_instr: got v=%b pc=%h i=%h want v=1 pc=4", instr_valid, instr_pc, instr); end
`else
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== ~32'h0) begin failures++; $display("FAIL c2_instr: got v=%b pc=%h i=%h want v=1 pc=0 i=ffffffff", instr_valid, instr_pc, instr); end
`endif
    repeat (14) step();
    checks++; if (log_pc.size() < 6) begin failures++; $display("FAIL reset_seq_len: got %0d want >=6", log_pc.size()); end
    for (int i = 0; i < 6 && i < log_pc.size(); i++) begin
      checks++;
      if (log_pc[i] !== 32'(4 * i) || log_instr[i] !== ~32'(4 * i)) begin
        failures++; $display("FAIL reset_seq[%0d]: got pc=%h i=%h want pc=%h", i, log_pc[i], log_instr[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    apply_reset();
    repeat (12) step();
    checks++; if (req_log.size() != 2) begin failures++; $display("FAIL stall_req_count: got %0d want 2", req_log.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== ~32'h0) begin failures++; $display("FAIL stall_head: got v=%b pc=%h i=%h want v=1 pc=0", instr_valid, instr_pc, instr); end
    instr_ready = 1'b1;
    repeat (20) step();
    checks++; if (log_pc.size() < 8) begin failures++; $display("FAIL stall_seq_len: got %0d want >=8", log_pc.size()); end
    for (int i = 0; i < 8 && i < log_pc.size(); i++) begin
      checks++;
      if (log_pc[i] !== 32'(4 * i) || log_instr[i] !== ~32'(4 * i)) begin
        failures++; $display("FAIL stall_seq[%0d]: got pc=%h i=%h want pc=%h", i, log_pc[i], log_instr[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_drop();
    lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    step(); step();
    checks++; if (req_log.size() != 2) begin failures++; $display("FAIL drop_inflight: got %0d want 2", req_log.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL drop_req_in_redirect: got %b want 0", imem_req_valid); end
    clear_logs();
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drop_stale_visible: got %b want 0", instr_valid); end
    repeat (20) step();
    checks++; if (req_log.size() < 1 || req_log[0] !== 32'h100) begin failures++; $display("FAIL drop_first_req: got n=%0d want addr 100", req_log.size()); end
    checks++; if (log_pc.size() < 4) begin failures++; $display("FAIL drop_seq_len: got %0d want >=4", log_pc.size()); end
    for (int i = 0; i < 4 && i < log_pc.size(); i++) begin
      checks++;
      if (log_pc[i] !== 32'h100 + 32'(4 * i) || log_instr[i] !== ~(32'h100 + 32'(4 * i))) begin
        failures++; $display("FAIL drop_seq[%0d]: got pc=%h i=%h want pc=%h", i, log_pc[i], log_instr[i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_same_cycle();
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL same_req_in_redirect: got %b want 0", imem_req_valid); end
    clear_logs();
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin failures++; $display("FAIL same_next_req: got v=%b a=%h want v=1 a=300", imem_req_valid, imem_req_addr); end
    checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin failures++; $display("FAIL same_flushed: got v=%b i=%h want v=0 i=%h", instr_valid, instr, NOP); end
    repeat (15) step();
    checks++; if (log_pc.size() < 3) begin failures++; $display("FAIL same_seq_len: got %0d want >=3", log_pc.size()); end
    for (int i = 0; i < 3 && i < log_pc.size(); i++) begin
      checks++;
      if (log_pc[i] !== 32'h300 + 32'(4 * i) || log_instr[i] !== ~(32'h300 + 32'(4 * i))) begin
        failures++; $display("FAIL same_seq[%0d]: got pc=%h i=%h want pc=%h", i, log_pc[i], log_instr[i], 32'h300 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_align_wrap();
    logic [31:0] exp_pc;
    lat = 2; imem_req_ready = 1'b0; instr_ready = 1'b1;
    apply_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL align_req: got v=%b a=%h want v=1 a=200", imem_req_valid, imem_req_addr); end
    clear_logs();
    imem_req_ready = 1'b1;
    repeat (12) step();
    checks++; if (log_pc.size() < 2 || log_pc[0] !== 32'h200 || log_instr[0] !== ~32'h200 || log_pc[1] !== 32'h204) begin
      failures++; $display("FAIL align_seq: got n=%0d want pcs 200,204", log_pc.size());
    end

    imem_req_ready = 1'b0;
    apply_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req: got a=%h want fffffffc", imem_req_addr); end
    clear_logs();
    imem_req_ready = 1'b1;
    repeat (15) step();
    checks++; if (req_log.size() < 2 || req_log[1] !== 32'h0) begin failures++; $display("FAIL wrap_req_seq: got n=%0d want second addr 0", req_log.size()); end
    checks++; if (log_pc.size() < 3) begin failures++; $display("FAIL wrap_seq_len: got %0d want >=3", log_pc.size()); end
    for (int i = 0; i < 3 && i < log_pc.size(); i++) begin
      exp_pc = 32'hFFFF_FFFC + 32'(4 * i);
      checks++;
      if (log_pc[i] !== exp_pc || log_instr[i] !== ~exp_pc) begin
        failures++; $display("FAIL wrap_seq[%0d]: got pc=%h i=%h want pc=%h", i, log_pc[i], log_instr[i], exp_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b0;
    apply_reset();
    step();
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_req: got %b want 1", imem_req_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL arst_req_valid: got %b want 0", imem_req_valid); end
    apply_reset();
    repeat (15) step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL arst_full_pre: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL arst_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== NOP) begin failures++; $display("FAIL arst_instr: got %h want %h", instr, NOP); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL arst_instr_pc: got %h want 0", instr_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL arst_req_full: got %b want 0", imem_req_valid); end
    apply_reset();
    instr_ready = 1'b1;
    repeat (15) step();
    checks++; if (req_log.size() < 1 || req_log[0] !== 32'h0) begin failures++; $display("FAIL arst_restart_req: got n=%0d want first addr 0", req_log.size()); end
    checks++; if (log_pc.size() < 2 || log_pc[0] !== 32'h0 || log_pc[1] !== 32'h4) begin failures++; $display("FAIL arst_restart_seq: got n=%0d want pcs 0,4", log_pc.size()); end
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    test_reset();
    test_stall();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_align_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
